cfg_chain_loader: RTL and testbench

- Parametrised successor to the single-chain decoder/scan-chain arrangement in the overlay top level.
- Accepts a UART byte stream and drives CHAINS independent configuration scan chains, each CHAIN_LEN bits long.
- Supports three chain operations: write with simultaneous readback, non-destructive readback, and a single user-clock step.
- Sits between the UART and the overlay fabric; replaces the fixed single-head/tail decoder.

---
 rtl/cfg_chain_loader_if.sv | 35 +++
 rtl/cfg_chain_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_chain_loader_if.sv
// cfg_chain_loader_if: UART byte stream and scan-chain signals of the
// configuration chain loader.
//   RX_VALID/RX_DATA   received byte strobe and data
//   TX_READY           transmitter can take a byte
//   TX_VALID/TX_DATA   byte to transmit (one-cycle strobe)
//   SHIFT_HEAD/TAIL    serial data into / out of each chain
//   SHIFT_ENABLE       per-chain shift enable
//   USER_STEP          one-cycle user-clock enable
//   BUSY, OVERRUN      status
// modport master is the loader side, slave is the UART/fabric side.
interface cfg_chain_loader_if #(
    parameter int unsigned CHAINS = 4
);
    logic              RX_VALID;
    logic [7:0]        RX_DATA;
    logic              TX_READY;
    logic              TX_VALID;
    logic [7:0]        TX_DATA;
    logic [CHAINS-1:0] SHIFT_HEAD;
    logic [CHAINS-1:0] SHIFT_TAIL;
    logic [CHAINS-1:0] SHIFT_ENABLE;
    logic              USER_STEP;
    logic              BUSY;
    logic              OVERRUN;

    modport master (
        input  RX_VALID, RX_DATA, TX_READY, SHIFT_TAIL,
        output TX_VALID, TX_DATA, SHIFT_HEAD, SHIFT_ENABLE, USER_STEP, BUSY, OVERRUN
    );

    modport slave (
        output RX_VALID, RX_DATA, TX_READY, SHIFT_TAIL,
        input  TX_VALID, TX_DATA, SHIFT_HEAD, SHIFT_ENABLE, USER_STEP, BUSY, OVERRUN
    );
endinterface

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: decodes a UART command stream and drives CHAINS scan
// chains of CHAIN_LEN bits each (write with readback, recirculating read,
// user-clock step).
// Ports:
//   SYSCLK  system clock, rising edge
//   SYSRST  asynchronous active-low reset
//   bus     cfg_chain_loader_if.master (UART RX/TX, chain head/tail/enable,
//           USER_STEP, BUSY, OVERRUN)
module cfg_chain_loader #(
    parameter int unsigned CHAIN_LEN = 512,
    parameter int unsigned CHAINS    = 4
) (
    input  logic               SYSCLK,
    input  logic               SYSRST,
    cfg_chain_loader_if.master bus
);
    localparam int unsigned NBYTES = (CHAIN_LEN + 7) / 8;
    localparam int unsigned CW     = $clog2(CHAIN_LEN + 1);
    localparam int unsigned BW     = $clog2(NBYTES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GETB  = 3'd1,
        SHIFT = 3'd2,
        SEND  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        rx_buf_q;
    logic              rx_full_q;
    logic              overrun_q;
    logic [CHAINS-1:0] sel_q, sel_d;
    logic              op_read_q, op_read_d;
    logic [7:0]        sh_byte_q, sh_byte_d;
    logic [7:0]        out_byte_q, out_byte_d;
    logic [2:0]        bit_q, bit_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     byte_q, byte_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_pend_q, tx_pend_d;
    logic              user_step_q, user_step_d;
    logic              busy_q, busy_d;
    logic [CHAINS-1:0] se_q, se_d;

    logic              consume;
    logic              ovr_clr;
    logic              tail_k;
    logic              k_ok;
    logic [7:0]        out_next;

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        op_read_d   = op_read_q;
        sh_byte_d   = sh_byte_q;
        out_byte_d  = out_byte_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        byte_d      = byte_q;
        tx_data_d   = tx_data_q;
        tx_pend_d   = tx_pend_q;
        user_step_d = 1'b0;
        consume     = 1'b0;
        ovr_clr     = 1'b0;
        out_next    = out_byte_q;
        tail_k      = |(bus.SHIFT_TAIL & se_q);
        k_ok        = 7'(rx_buf_q[5:0]) < 7'(CHAINS);

        case (state_q)
            IDLE: begin
                if (rx_full_q) begin
                    consume    = 1'b1;
                    cnt_d      = '0;
                    byte_d     = '0;
                    bit_d      = '0;
                    out_byte_d = '0;
                    sel_d      = CHAINS'(1) << rx_buf_q[5:0];
                    case (rx_buf_q[7:6])
                        2'b00: begin
                            ovr_clr   = 1'b1;
                            tx_data_d = 8'hA5;
                            tx_pend_d = 1'b1;
                            state_d   = RESP;
                        end
                        2'b01, 2'b10: begin
                            if (k_ok) begin
                                op_read_d = rx_buf_q[7];
                                state_d   = rx_buf_q[7] ? SHIFT : GETB;
                            end else begin
                                tx_data_d = 8'hEE;
                                tx_pend_d = 1'b1;
                                state_d   = RESP;
                            end
                        end
                        default: begin
                            // Pulse first; the reply is armed one cycle later.
                            user_step_d = 1'b1;
                            tx_data_d   = 8'h5A;
                            tx_pend_d   = 1'b0;
                            state_d     = RESP;
                        end
                    endcase
                end
            end
            GETB: begin
                if (rx_full_q) begin
                    consume    = 1'b1;
                    sh_byte_d  = rx_buf_q;
                    bit_d      = '0;
                    out_byte_d = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                out_next[bit_q] = tail_k;
                out_byte_d      = out_next;
                sh_byte_d       = {1'b0, sh_byte_q[7:1]};
                bit_d           = bit_q + 3'd1;
                cnt_d           = cnt_q + CW'(1);
                // Byte ends after 8 bits or at the last chain bit.
                if (bit_q == 3'd7 || cnt_q == CW'(CHAIN_LEN - 1)) begin
                    tx_data_d = out_next;
                    tx_pend_d = 1'b1;
                    byte_d    = byte_q + BW'(1);
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (bus.TX_READY) begin
                    tx_pend_d = 1'b0;
                    if (byte_q == BW'(NBYTES)) begin
                        state_d = IDLE;
                    end else if (op_read_q) begin
                        bit_d      = '0;
                        out_byte_d = '0;
                        state_d    = SHIFT;
                    end else begin
                        state_d = GETB;
                    end
                end
            end
            RESP: begin
                if (!tx_pend_q) begin
                    tx_pend_d = 1'b1;
                end else if (bus.TX_READY) begin
                    tx_pend_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        se_d   = (state_d == SHIFT) ? sel_d : '0;
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge SYSCLK or negedge SYSRST) begin
        if (!SYSRST) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            op_read_q   <= 1'b0;
            sh_byte_q   <= '0;
            out_byte_q  <= '0;
            bit_q       <= '0;
            cnt_q       <= '0;
            byte_q      <= '0;
            tx_data_q   <= '0;
            tx_pend_q   <= 1'b0;
            user_step_q <= 1'b0;
            busy_q      <= 1'b0;
            se_q        <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            op_read_q   <= op_read_d;
            sh_byte_q   <= sh_byte_d;
            out_byte_q  <= out_byte_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            tx_data_q   <= tx_data_d;
            tx_pend_q   <= tx_pend_d;
            user_step_q <= user_step_d;
            busy_q      <= busy_d;
            se_q        <= se_d;
        end
    end

    // One-byte RX holding buffer; a byte arriving while full is dropped.
    always_ff @(posedge SYSCLK or negedge SYSRST) begin
        if (!SYSRST) begin
            rx_buf_q  <= '0;
            rx_full_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.RX_VALID && (!rx_full_q || consume)) begin
                rx_buf_q  <= bus.RX_DATA;
                rx_full_q <= 1'b1;
            end else if (consume) begin
                rx_full_q <= 1'b0;
            end
            overrun_q <= (overrun_q & ~ovr_clr) | (bus.RX_VALID & rx_full_q & ~consume);
        end
    end

    // Strobe qualified by TX_READY so it can never fire while the UART is busy.
    assign bus.TX_VALID     = tx_pend_q & bus.TX_READY;
    assign bus.TX_DATA      = tx_data_q;
    // READ recirculates the tail; WRITE presents the current data bit.
    assign bus.SHIFT_HEAD   = op_read_q ? (bus.SHIFT_TAIL & se_q)
                                        : ({CHAINS{sh_byte_q[0]}} & se_q);
    assign bus.SHIFT_ENABLE = se_q;
    assign bus.USER_STEP    = user_step_q;
    assign bus.BUSY         = busy_q;
    assign bus.OVERRUN      = overrun_q;
endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: directed bench for cfg_chain_loader with CHAIN_LEN=12,
// CHAINS=2. Behavioural shift registers model the chains; a command-level
// model predicts replies and chain contents.
module tb_cfg_chain_loader;
    localparam int unsigned CL = 12;
    localparam int unsigned NC = 2;
    localparam int unsigned NB = (CL + 7) / 8;

    logic SYSCLK = 1'b0;
    logic SYSRST = 1'b1;
    always #5 SYSCLK = ~SYSCLK;

    cfg_chain_loader_if #(.CHAINS(NC)) bus ();

    cfg_chain_loader #(.CHAIN_LEN(CL), .CHAINS(NC)) dut (
        .SYSCLK (SYSCLK),
        .SYSRST (SYSRST),
        .bus    (bus)
    );

    // Behavioural scan chains: head enters at the MSB, tail is bit 0.
    logic [CL-1:0] env_chain [NC] = '{default: '0};
    always @(posedge SYSCLK) begin
        for (int c = 0; c < int'(NC); c++) begin
            if (bus.SHIFT_ENABLE[c]) env_chain[c] <= {bus.SHIFT_HEAD[c], env_chain[c][CL-1:1]};
        end
    end
    always_comb begin
        bus.SHIFT_TAIL = '0;
        for (int c = 0; c < int'(NC); c++) bus.SHIFT_TAIL[c] = env_chain[c][0];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt [NC];
    int step_cnt;
    int exp_q [$];
    logic [7:0] rx_log [$];

    // Command-level model state.
    logic [CL-1:0] mdl_chain [NC];
    bit            mdl_known [NC];
    int            mdl_need;
    int            mdl_k;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic mdl_accept(input logic [7:0] b);
        if (mdl_need > 0) begin
            int j;
            int nb;
            int mask;
            int cur;
            j    = int'(NB) - mdl_need;
            nb   = (j == int'(NB) - 1 && (CL % 8) != 0) ? int'(CL % 8) : 8;
            mask = (1 << nb) - 1;
            cur  = int'(mdl_chain[mdl_k]);
            exp_q.push_back(mdl_known[mdl_k] ? ((cur >> (8 * j)) & mask) : -1);
            cur = (cur & ~(mask << (8 * j))) | ((int'(b) & mask) << (8 * j));
            mdl_chain[mdl_k] = CL'(cur);
            mdl_need--;
            if (mdl_need == 0) mdl_known[mdl_k] = 1'b1;
        end else begin
            int k;
            k = int'(b[5:0]);
            case (b[7:6])
                2'b00: exp_q.push_back(8'hA5);
                2'b01: begin
                    if (k < int'(NC)) begin
                        mdl_need = int'(NB);
                        mdl_k    = k;
                    end else exp_q.push_back(8'hEE);
                end
                2'b10: begin
                    if (k < int'(NC)) begin
                        for (int j = 0; j < int'(NB); j++) begin
                            int nb;
                            nb = (j == int'(NB) - 1 && (CL % 8) != 0) ? int'(CL % 8) : 8;
                            exp_q.push_back(mdl_known[k] ?
                                ((int'(mdl_chain[k]) >> (8 * j)) & ((1 << nb) - 1)) : -1);
                        end
                    end else exp_q.push_back(8'hEE);
                end
                default: exp_q.push_back(8'h5A);
            endcase
        end
    endtask

    // Per-cycle output checks against the model.
    always @(negedge SYSCLK) begin
        if (SYSRST) begin
            check("se_onehot0", 32'($countones(bus.SHIFT_ENABLE) <= 1), 32'd1);
            for (int c = 0; c < int'(NC); c++) if (bus.SHIFT_ENABLE[c]) en_cnt[c]++;
            if (bus.USER_STEP) step_cnt++;
            if (bus.TX_VALID) begin
                check("tx_valid_needs_ready", 32'(bus.TX_READY), 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got %02h, required no byte", bus.TX_DATA);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (e >= 0) check("tx_data", 32'(bus.TX_DATA), 32'(e));
                end
                rx_log.push_back(bus.TX_DATA);
            end
        end
    end

    task automatic clear_stats();
        for (int c = 0; c < int'(NC); c++) en_cnt[c] = 0;
        step_cnt = 0;
        rx_log.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit acc);
        @(posedge SYSCLK);
        #1;
        bus.RX_VALID = 1'b1;
        bus.RX_DATA  = b;
        if (acc) mdl_accept(b);
        @(posedge SYSCLK);
        #1;
        bus.RX_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        repeat (3) @(negedge SYSCLK);
        while ((bus.BUSY || exp_q.size() != 0) && t < 500) begin
            @(negedge SYSCLK);
            t++;
        end
        check({name, "_busy"}, 32'(bus.BUSY), 32'd0);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_log(input string name, input int n,
                             input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] e [3];
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        check({name, "_count"}, 32'(rx_log.size()), 32'(n));
        for (int i = 0; i < n && i < rx_log.size(); i++) check({name, "_byte"}, 32'(rx_log[i]), 32'(e[i]));
    endtask

    task automatic check_chain0(input string name, input logic [CL-1:0] lit);
        check({name, "_model"}, 32'(mdl_chain[0]), 32'(lit));
        check({name, "_chain"}, 32'(env_chain[0]), 32'(mdl_chain[0]));
    endtask

    initial begin
        int viol;
        bit seen;
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'h00;
        bus.TX_READY = 1'b1;
        for (int c = 0; c < int'(NC); c++) begin
            mdl_chain[c] = '0;
            mdl_known[c] = 1'b1;
        end
        mdl_need = 0;
        mdl_k    = 0;
        clear_stats();

        // Reset state
        #1 SYSRST = 1'b0;
        #12;
        check("rst_tx_valid", 32'(bus.TX_VALID), 32'd0);
        check("rst_tx_data", 32'(bus.TX_DATA), 32'd0);
        check("rst_se", 32'(bus.SHIFT_ENABLE), 32'd0);
        check("rst_head", 32'(bus.SHIFT_HEAD), 32'd0);
        check("rst_step", 32'(bus.USER_STEP), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_ovr", 32'(bus.OVERRUN), 32'd0);
        @(negedge SYSCLK) SYSRST = 1'b1;

        // 1: NOP
        clear_stats();
        send_byte(8'h00, 1'b1);
        wait_idle("nop");
        check_log("nop", 1, 8'hA5, 8'h00, 8'h00);
        check("nop_no_shift", 32'(en_cnt[0] + en_cnt[1]), 32'd0);

        // 2: first WRITE
        clear_stats();
        send_byte(8'h40, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h0F, 1'b1);
        wait_idle("wr1");
        check_log("wr1", 2, 8'h00, 8'h00, 8'h00);
        check("wr1_en0", 32'(en_cnt[0]), 32'd12);
        check("wr1_en1", 32'(en_cnt[1]), 32'd0);
        check_chain0("wr1", 12'hF3C);

        // 3: second WRITE returns prior contents
        clear_stats();
        send_byte(8'h40, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_idle("wr2");
        check_log("wr2", 2, 8'h3C, 8'h0F, 8'h00);
        check_chain0("wr2", 12'hFFF);

        // 4: READ, then out-of-range chain
        clear_stats();
        send_byte(8'h80, 1'b1);
        wait_idle("rd");
        check_log("rd", 2, 8'hFF, 8'h0F, 8'h00);
        check("rd_en0", 32'(en_cnt[0]), 32'd12);
        check_chain0("rd", 12'hFFF);
        clear_stats();
        send_byte(8'h45, 1'b1);
        wait_idle("badk");
        check_log("badk", 1, 8'hEE, 8'h00, 8'h00);
        check("badk_no_shift", 32'(en_cnt[0] + en_cnt[1]), 32'd0);

        // 5: TX stall mid-WRITE
        clear_stats();
        bus.TX_READY = 1'b0;
        send_byte(8'h40, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (12) @(negedge SYSCLK);
        viol = 0;
        for (int i = 0; i < 38; i++) begin
            @(negedge SYSCLK);
            if (bus.SHIFT_ENABLE != '0 || bus.TX_VALID) viol++;
        end
        check("stall_quiet", 32'(viol), 32'd0);
        check("stall_en0", 32'(en_cnt[0]), 32'd8);
        check("stall_busy", 32'(bus.BUSY), 32'd1);
        bus.TX_READY = 1'b1;
        send_byte(8'hFF, 1'b1);
        wait_idle("stall");
        check_log("stall", 2, 8'hFF, 8'h0F, 8'h00);
        check("stall_en_total", 32'(en_cnt[0]), 32'd12);
        check_chain0("stall", 12'hFFF);

        // 5b: reset during SHIFT
        clear_stats();
        send_byte(8'h40, 1'b0);
        send_byte(8'h12, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge SYSCLK);
            if (bus.SHIFT_ENABLE[0]) seen = 1'b1;
        end
        check("mid_shift_reached", 32'(seen), 32'd1);
        #2 SYSRST = 1'b0;
        #1;
        check("async_rst_se", 32'(bus.SHIFT_ENABLE), 32'd0);
        check("async_rst_busy", 32'(bus.BUSY), 32'd0);
        mdl_need     = 0;
        mdl_known[0] = 1'b0;
        exp_q.delete();
        @(negedge SYSCLK) SYSRST = 1'b1;
        clear_stats();
        send_byte(8'h40, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h0F, 1'b1);
        wait_idle("rewr");
        check("rewr_en0", 32'(en_cnt[0]), 32'd12);
        check_chain0("rewr", 12'hF3C);

        // 6: overrun while stalled, STEP, NOP clears overrun
        clear_stats();
        bus.TX_READY = 1'b0;
        send_byte(8'h80, 1'b1);
        repeat (12) @(negedge SYSCLK);
        send_byte(8'hBF, 1'b1);
        send_byte(8'hBF, 1'b0);
        send_byte(8'hBF, 1'b0);
        @(negedge SYSCLK);
        check("ovr_set", 32'(bus.OVERRUN), 32'd1);
        bus.TX_READY = 1'b1;
        wait_idle("ovr");
        check_log("ovr", 3, 8'h3C, 8'h0F, 8'hEE);
        clear_stats();
        send_byte(8'hC0, 1'b1);
        wait_idle("step");
        check("step_pulse", 32'(step_cnt), 32'd1);
        check_log("step", 1, 8'h5A, 8'h00, 8'h00);
        check("ovr_sticky", 32'(bus.OVERRUN), 32'd1);
        clear_stats();
        send_byte(8'h00, 1'b1);
        wait_idle("clr");
        check_log("clr", 1, 8'hA5, 8'h00, 8'h00);
        check("ovr_cleared", 32'(bus.OVERRUN), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
